// File: rtl/dot_product_datapath_pkg.sv
// Shared sizing for the dot-product datapath and its matrix-multiplier controller.
package dot_product_datapath_pkg;

  localparam int DATA_W  = 8;
  localparam int ENTRIES = 8;
  localparam int ACC_W   = 2*DATA_W + 3;
  localparam int COUNT_W = 4;

  // Controller leaves Multiply when entry_count shows this value (the last sample).
  localparam int COUNT_TERMINAL = ENTRIES - 1;

  // Saturating counter step: stops at the run length, never wraps.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
    logic [COUNT_W-1:0] nxt;
    nxt = cnt;
    if (cnt < COUNT_W'(ENTRIES)) nxt = cnt + COUNT_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/dot_product_datapath_result_holding_reg.sv
// Held output register: result / result_valid / overrun with valid-ready consumption.
module result_holding_reg
  import dot_product_datapath_pkg::*;
#(
  parameter int RES_W = ACC_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [RES_W-1:0] load_data,
  input  logic             result_ready,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             overrun
);

  logic [RES_W-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  // Load beats consume; an unconsumed value being replaced flags overrun (sticky).
  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      result_d = load_data;
      valid_d  = 1'b1;
      if (valid_q && !result_ready) overrun_d = 1'b1;
    end else if (valid_q && result_ready) begin
      valid_d = 1'b0;
    end
  end

  // State update; reset is the only way to clear overrun.
  always_ff @(posedge clock) begin
    if (!reset) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: rtl/dot_product_datapath.sv
// Dot-product datapath: registered product, accumulator, entry counter, held result.
module dot_product_datapath
  import dot_product_datapath_pkg::*;
#(
  parameter int P_DATA_W  = DATA_W,
  parameter int P_ENTRIES = ENTRIES,
  parameter int P_ACC_W   = ACC_W,
  parameter int P_COUNT_W = COUNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_matrix,
  input  logic                 multiply_matrix,
  input  logic                 add,
  input  logic                 done,
  input  logic [P_DATA_W-1:0]  a_in,
  input  logic [P_DATA_W-1:0]  b_in,
  output logic [P_COUNT_W-1:0] entry_count,
  output logic [P_ACC_W-1:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 overrun
);

  localparam int PROD_W = 2*P_DATA_W;

  logic                 sample;
  logic [PROD_W-1:0]    p_q, p_d;
  logic                 p_valid_q, p_valid_d;
  logic [P_ACC_W-1:0]   partial_q, partial_d;
  logic [P_COUNT_W-1:0] count_q, count_d;

  // The add cycle needs no action of its own: the last product is folded in
  // because p_valid is still set, so add is only a controller-side marker.
  logic unused_add;
  assign unused_add = add;

  assign sample = load_matrix & multiply_matrix;

  // Product stage and entry counter; done ends the run and wins over a sample.
  always_comb begin
    p_d       = p_q;
    p_valid_d = sample;
    count_d   = count_q;
    if (sample) begin
      p_d = PROD_W'(a_in) * PROD_W'(b_in);
      if (count_q < P_COUNT_W'(P_ENTRIES)) count_d = count_q + P_COUNT_W'(1);
    end
    if (done) begin
      p_valid_d = 1'b0;
      count_d   = '0;
    end
  end

  // Accumulator: full-width add of each valid product, cleared by done.
  always_comb begin
    partial_d = partial_q;
    if (done)           partial_d = '0;
    else if (p_valid_q) partial_d = partial_q + P_ACC_W'(p_q);
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      partial_q <= '0;
      count_q   <= '0;
    end else begin
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
      partial_q <= partial_d;
      count_q   <= count_d;
    end
  end

  assign entry_count = count_q;

  result_holding_reg #(.RES_W(P_ACC_W)) u_hold (
    .clock        (clock),
    .reset        (reset),
    .load         (done),
    .load_data    (partial_q),
    .result_ready (result_ready),
    .result       (result),
    .result_valid (result_valid),
    .overrun      (overrun)
  );

endmodule

// File: doc/dot_product_datapath.md
# dot_product_datapath

- Arithmetic datapath driven by the matrix-multiplier control FSM.
- Each run streams one row/column pair of 8 unsigned operands, multiplies them pairwise through a registered product stage and accumulates the sum.
- Captures the dot product into a held output register with a valid/ready handshake.
- Returns `entry_count` to the controller, which uses it to leave its Multiply state.

## Interface
Parameters:
- DATA_W, 8, operand width (unsigned)
- ENTRIES, 8, operand pairs per run
- ACC_W, 2*DATA_W+3, accumulator/result width (holds ENTRIES × max product without overflow)
- COUNT_W, 4, entry counter width

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- load_matrix  in  1  controller: operands on a_in/b_in are valid this cycle
- multiply_matrix  in  1  controller: multiply enable
- add  in  1  controller: final-accumulate (pipeline flush) cycle
- done  in  1  controller: store cycle, capture result
- a_in  in  DATA_W  row operand
- b_in  in  DATA_W  column operand
- entry_count  out  COUNT_W  pairs sampled so far in current run
- result  out  ACC_W  captured dot product
- result_valid  out  1  result holds an unconsumed value
- result_ready  in  1  consumer accepts result when result_valid & result_ready
- overrun  out  1  sticky: a result was overwritten before being consumed

## Operation
- Sample condition: load_matrix & multiply_matrix. Either alone samples nothing.
- On a sample edge:
  - product register p_q <= a_in*b_in; p_valid <= 1; otherwise p_valid <= 0.
  - entry_count increments, saturating at ENTRIES (8); never wraps.
- Accumulate stage: on every edge with p_valid=1, partial <= partial + p_q. Full-width addition, no truncation.
- add cycle: the cycle after the 8th sample. p_valid is 1 from the 8th pair, so partial becomes final at the end of this cycle. add asserted with p_valid=0 is a no-op.
- done edge:
  - result <= partial, result_valid <= 1.
  - partial, p_valid and entry_count cleared to 0, ready for the next run.
- Handshake:
  - result_valid & result_ready at an edge clears result_valid, unless done loads a new value on the same edge.
  - done together with result_valid & result_ready: old value consumed, new value loaded, result_valid stays 1, no overrun.
  - done with result_valid=1 and result_ready=0: new value overwrites result, overrun <= 1.
  - result holds stable while result_valid=1 and no done.
- overrun is cleared only by reset.
- Reset (reset=0 at an edge):
  - entry_count, result, partial, p_q = 0.
  - result_valid, p_valid, overrun = 0.
  - Reset overrides all other inputs, including in the middle of a run.

## Timing
- Controller samples entry_count combinationally. Run cycle sequence:
  - Multiply cycles with entry_count = 0..7; the controller exits Multiply on the cycle entry_count=7, which is the 8th sample.
  - Accumulate cycle: entry_count=8.
  - Store cycle: entry_count=8, done=1.
  - Then Idle: entry_count=0.
- Latency: result_valid rises 2 edges after the edge sampling the 8th pair.
- Product to partial: 1 cycle. No combinational path from any input to any output except none: all outputs are registered.
- Back-to-back runs: the Idle cycle between runs is sufficient; no extra bubbles are required.

## Structure
- Shared package holds DATA_W, ENTRIES, ACC_W, COUNT_W defaults. The controller's entry-count terminal value (ENTRIES-1) is defined there too.
- One sub-module: result_holding_reg. It owns result, result_valid, overrun and the handshake/overwrite rules.
- Product stage, accumulator and counter stay in the top module.

## Test plan
- Reset: hold reset=0 with random inputs → entry_count=0, result=0, result_valid=0, overrun=0.
- Basic run: a_in=1..8, b_in=1 → entry_count 0..7 during Multiply; result=36 with result_valid high 2 edges after the 8th sample; entry_count=0 in the following Idle.
- Max values: all a_in=b_in=255 → result=520200, no truncation.
- Backpressure: result_ready=0 across two runs (a=b=1, then a=b=2) → second done sets overrun=1 and result=32; overrun holds until reset.
- Simultaneous done and handshake: result_valid=1 with result_ready=1 on the done edge → result_valid stays 1, new value loaded, overrun stays 0.
- Mid-run reset: reset=0 after 3 samples → all cleared; a following full run with a=b=3 gives result=72.
